// File: rtl/cache_pkg.sv
`default_nettype none
//============================================================================
// Module   : cache_pkg
// Brief    : Shared geometry defaults, derived field widths and FSM encoding
// Revision : 1.0
//============================================================================
package cache_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_BLOCK_BYTES = 32;
    localparam int DEFAULT_NUM_LINES   = 8;

    localparam int WORD_BITS      = 32;
    localparam int OFFSET_WIDTH   = $clog2(DEFAULT_BLOCK_BYTES);
    localparam int INDEX_WIDTH    = $clog2(DEFAULT_NUM_LINES);
    localparam int TAG_WIDTH      = DEFAULT_ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int WORD_SEL_WIDTH = OFFSET_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_if.sv
`default_nettype none
//============================================================================
// Module   : cache_if
// Brief    : CPU-side and memory-side bus signals of the cache controller
// Revision : 1.0
//============================================================================
interface cache_if
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES
);
    logic [ADDR_WIDTH-1:0]    cpu_addr;
    logic [WORD_BITS-1:0]     cpu_wdata;
    logic                     cpu_read;
    logic                     cpu_write;
    logic [WORD_BITS-1:0]     cpu_rdata;
    logic                     cpu_ready;

    logic [ADDR_WIDTH-1:0]    mem_addr_block;
    logic [BLOCK_BYTES*8-1:0] mem_wdata_block;
    logic                     mem_read;
    logic                     mem_write;
    logic [BLOCK_BYTES*8-1:0] mem_rdata_block;
    logic                     mem_ready;

    // Environment side: drives CPU requests and memory responses.
    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write,
        output mem_rdata_block, mem_ready,
        input  cpu_rdata, cpu_ready,
        input  mem_addr_block, mem_wdata_block, mem_read, mem_write
    );

    // Cache controller side.
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
        input  mem_rdata_block, mem_ready,
        output cpu_rdata, cpu_ready,
        output mem_addr_block, mem_wdata_block, mem_read, mem_write
    );

endinterface
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
//============================================================================
// Module   : cache_line_array
// Brief    : Tag/valid/dirty/data store, async read port, one sync write port
// Revision : 1.0
//============================================================================
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINES     = DEFAULT_NUM_LINES,
    parameter int IDX_W     = INDEX_WIDTH,
    parameter int TAG_W     = TAG_WIDTH,
    parameter int SEL_W     = WORD_SEL_WIDTH,
    parameter int LINE_BITS = DEFAULT_BLOCK_BYTES * 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [IDX_W-1:0]     rd_index,
    output logic                      rd_valid,
    output logic                      rd_dirty,
    output logic [TAG_W-1:0]          rd_tag,
    output logic [LINE_BITS-1:0]      rd_data,
    input  wire logic                 wr_en,
    input  wire logic                 wr_fill,
    input  wire logic [IDX_W-1:0]     wr_index,
    input  wire logic [TAG_W-1:0]     wr_tag,
    input  wire logic [SEL_W-1:0]     wr_word,
    input  wire logic [WORD_BITS-1:0] wr_word_data,
    input  wire logic [LINE_BITS-1:0] wr_line_data
);

    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TAG_W-1:0]     tags  [LINES];
    logic [LINE_BITS-1:0] data  [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

    // A fill installs a clean line; a word store marks the line dirty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            if (wr_fill) begin
                valid[wr_index] <= 1'b1;
                dirty[wr_index] <= 1'b0;
            end else begin
                dirty[wr_index] <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_fill) begin
                data[wr_index] <= wr_line_data;
                tags[wr_index] <= wr_tag;
            end else begin
                data[wr_index][wr_word*WORD_BITS +: WORD_BITS] <= wr_word_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
//============================================================================
// Module   : cache_controller
// Brief    : Direct-mapped write-back write-allocate cache controller
// Revision : 1.0
//============================================================================
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int BLOCK_BYTES = DEFAULT_BLOCK_BYTES,
    parameter int NUM_LINES   = DEFAULT_NUM_LINES
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cache_if.slave      bus,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int LINE_BITS = BLOCK_BYTES * 8;
    localparam int OFF_W     = $clog2(BLOCK_BYTES);
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int SEL_W     = OFF_W - 2;

    state_t state;
    state_t state_d;

    logic                    retry;
    logic                    retry_d;
    logic                    req_write;
    logic [ADDR_WIDTH-1:2]   req_addr;
    logic [WORD_BITS-1:0]    req_wdata;

    logic                    cpu_ready_q;
    logic [WORD_BITS-1:0]    cpu_rdata_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [LINE_BITS-1:0]    mem_wdata_q;

    logic [IDX_W-1:0]        req_index;
    logic [TAG_W-1:0]        req_tag;
    logic [SEL_W-1:0]        req_sel;

    logic                    line_valid;
    logic                    line_dirty;
    logic [TAG_W-1:0]        line_tag;
    logic [LINE_BITS-1:0]    line_data;
    logic [WORD_BITS-1:0]    sel_word;
    logic                    hit;

    logic                    accept;
    logic                    ready_d;
    logic                    load_rdata;
    logic                    hit_inc;
    logic                    miss_inc;
    logic                    start_wb;
    logic                    start_alloc;
    logic                    arr_we;
    logic                    arr_fill;

    assign req_index = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag   = req_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
    assign req_sel   = req_addr[OFF_W-1:2];
    assign sel_word  = line_data[req_sel*WORD_BITS +: WORD_BITS];
    assign hit       = line_valid && (line_tag == req_tag);

    assign bus.cpu_ready       = cpu_ready_q;
    assign bus.cpu_rdata       = cpu_rdata_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_addr_block  = mem_addr_q;
    assign bus.mem_wdata_block = mem_wdata_q;

    cache_line_array #(
        .LINES     (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .SEL_W     (SEL_W),
        .LINE_BITS (LINE_BITS)
    ) u_lines (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (req_index),
        .rd_valid     (line_valid),
        .rd_dirty     (line_dirty),
        .rd_tag       (line_tag),
        .rd_data      (line_data),
        .wr_en        (arr_we),
        .wr_fill      (arr_fill),
        .wr_index     (req_index),
        .wr_tag       (req_tag),
        .wr_word      (req_sel),
        .wr_word_data (req_wdata),
        .wr_line_data (bus.mem_rdata_block)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // retry marks the COMPARE that follows a fill: it always hits but was
    // already counted as a miss, so neither counter may move.
    always_comb begin
        state_d     = state;
        retry_d     = retry;
        accept      = 1'b0;
        ready_d     = 1'b0;
        load_rdata  = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        start_wb    = 1'b0;
        start_alloc = 1'b0;
        arr_we      = 1'b0;
        arr_fill    = 1'b0;
        case (state)
            IDLE: begin
                if (!cpu_ready_q && (bus.cpu_read || bus.cpu_write)) begin
                    accept  = 1'b1;
                    retry_d = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    ready_d    = 1'b1;
                    load_rdata = !req_write;
                    arr_we     = req_write;
                    hit_inc    = !retry;
                    retry_d    = 1'b0;
                    state_d    = IDLE;
                end else begin
                    miss_inc = !retry;
                    if (line_valid && line_dirty) begin
                        start_wb = 1'b1;
                        state_d  = WRITEBACK;
                    end else begin
                        start_alloc = 1'b1;
                        state_d     = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (bus.mem_ready) begin
                    start_alloc = 1'b1;
                    state_d     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (bus.mem_ready) begin
                    arr_we   = 1'b1;
                    arr_fill = 1'b1;
                    retry_d  = 1'b1;
                    state_d  = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry       <= 1'b0;
            req_write   <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            retry       <= retry_d;
            cpu_ready_q <= ready_d;
            mem_read_q  <= start_alloc;
            mem_write_q <= start_wb;
            if (accept) begin
                req_write <= bus.cpu_write;
                req_addr  <= bus.cpu_addr[ADDR_WIDTH-1:2];
                req_wdata <= bus.cpu_wdata;
            end
            if (load_rdata) begin
                cpu_rdata_q <= sel_word;
            end
            // Address and line stay put until the next transfer is launched.
            if (start_wb) begin
                mem_addr_q  <= {line_tag, req_index, {OFF_W{1'b0}}};
                mem_wdata_q <= line_data;
            end else if (start_alloc) begin
                mem_addr_q  <= {req_tag, req_index, {OFF_W{1'b0}}};
            end
            if (hit_inc) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_inc) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
